// File: rtl/tff_bank_ctrl_if.sv
// Command channel for tff_bank_ctrl: valid/ready handshake carrying an opcode and a data word.
interface tff_bank_ctrl_if #(
  parameter int unsigned WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/tff_bank_ctrl.sv
// Sequencer for a bank of T flip-flops: executes clear/load/up/down commands and checks
// every step of the bank against a tracked expected value.
module tff_bank_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  tff_bank_ctrl_if.slave   cmd,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             tff_reset,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {StInit, StIdle, StClr, StApply, StSettle} state_e;

  localparam logic [1:0] OpClear = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             tff_reset_q, tff_reset_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  // Bit i toggles when all lower bits are 1 (count up) or all 0 (count down).
  function automatic logic [WIDTH-1:0] step_mask(input logic [WIDTH-1:0] v, input logic down);
    logic carry;
    step_mask = '0;
    carry     = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step_mask[i] = carry;
      carry        = carry & (v[i] ^ down);
    end
  endfunction

  function automatic logic [WIDTH-1:0] step_val(input logic [WIDTH-1:0] v, input logic down);
    step_val = down ? (v - WIDTH'(1)) : (v + WIDTH'(1));
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StInit;
      t_q         <= '0;
      tff_reset_q <= 1'b1;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      op_q        <= 2'b00;
      exp_q       <= '0;
      rem_q       <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      tff_reset_q <= tff_reset_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      op_q        <= op_d;
      exp_q       <= exp_d;
      rem_q       <= rem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    tff_reset_d = tff_reset_q;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;
    err_d       = err_q;
    op_d        = op_q;
    exp_d       = exp_q;
    rem_d       = rem_q;
    case (state_q)
      StInit: begin
        state_d     = StIdle;
        tff_reset_d = 1'b0;
        cmd_ready_d = 1'b1;
      end
      StIdle: begin
        t_d = '0;
        if (cmd.cmd_valid && cmd_ready_q) begin
          op_d  = cmd.cmd_op;
          rem_d = cmd.cmd_data;
          err_d = 1'b0;
          if (cmd.cmd_op == OpClear) begin
            state_d     = StClr;
            tff_reset_d = 1'b1;
            exp_d       = '0;
            cmd_ready_d = 1'b0;
          end else if (cmd.cmd_op == OpLoad) begin
            state_d     = StApply;
            t_d         = q ^ cmd.cmd_data;
            exp_d       = cmd.cmd_data;
            cmd_ready_d = 1'b0;
          end else if (cmd.cmd_data == '0) begin
            // Zero-length count completes without leaving IDLE.
            done_d = 1'b1;
          end else begin
            state_d     = StApply;
            t_d         = step_mask(q, cmd.cmd_op[0]);
            exp_d       = step_val(q, cmd.cmd_op[0]);
            cmd_ready_d = 1'b0;
          end
        end
      end
      StClr, StApply: begin
        state_d     = StSettle;
        t_d         = '0;
        tff_reset_d = 1'b0;
      end
      StSettle: begin
        if (q != exp_q) begin
          err_d       = 1'b1;
          state_d     = StIdle;
          done_d      = 1'b1;
          cmd_ready_d = 1'b1;
        end else if (op_q[1] && (rem_q > WIDTH'(1))) begin
          rem_d   = rem_q - WIDTH'(1);
          exp_d   = step_val(exp_q, op_q[0]);
          t_d     = step_mask(q, op_q[0]);
          state_d = StApply;
        end else begin
          state_d     = StIdle;
          done_d      = 1'b1;
          cmd_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = StInit;
        t_d         = '0;
        tff_reset_d = 1'b1;
        cmd_ready_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    t             = t_q;
    tff_reset     = tff_reset_q;
    cmd.cmd_ready = cmd_ready_q;
    busy          = ~cmd_ready_q;
    done          = done_q;
    err           = err_q;
  end

endmodule

// File: doc/tff_bank_ctrl.md
# tff_bank_ctrl

Sequencing controller for a bank of WIDTH `T_FF` instances (toggle-on-posedge when T=1, active-high `reset`). It accepts commands over a valid/ready handshake, drives the bank's T inputs and reset, and reads back Q. Supported commands are clear, load-value, count-up by N and count-down by N. Every step is verified against an internally tracked expected value. It sits between a command source and the T flip-flop datapath, so that nothing else touches the bank directly.

## Interface
- `WIDTH`, 4, number of T_FFs in the bank (≥1)
- `clk` in 1, sole clock, rising edge; bank shares it
- `reset` in 1, asynchronous, active-low controller reset
- `cmd_valid` in 1, command present
- `cmd_ready` out 1, controller can accept; transfer on `cmd_valid && cmd_ready` at posedge
- `cmd_op` in 2, 00 CLEAR, 01 LOAD, 10 UP, 11 DOWN
- `cmd_data` in WIDTH, LOAD target value, or UP/DOWN step count N; ignored for CLEAR
- `q` in WIDTH, Q outputs of the bank
- `t` out WIDTH, T inputs of the bank (registered)
- `tff_reset` out 1, active-high reset to every bank T_FF (registered)
- `busy` out 1, command in progress (= !cmd_ready)
- `done` out 1, one-cycle pulse on command completion
- `err` out 1, verify mismatch on last command; sticky until next accepted command

## Operation
- States: INIT, IDLE, CLR, APPLY, SETTLE.
- **Reset (async, `reset`=0):** state INIT; `t`=0, `tff_reset`=1, `cmd_ready`=0, `busy`=1, `done`=0, `err`=0. The bank is held in reset.
- **INIT:** at the first posedge after release, go to IDLE, `tff_reset`<=0, `cmd_ready`<=1.
- **IDLE:** `t`=0, `cmd_ready`=1. On accept, latch op and data, clear `err`, and go as follows:
  - CLEAR: to CLR, `tff_reset`<=1, expected=0.
  - LOAD: to APPLY, `t`<=`q ^ cmd_data`, expected=`cmd_data`.
  - UP/DOWN with N=0: stay in IDLE, pulse `done` next cycle (`cmd_ready` stays 1).
  - UP/DOWN with N>0: to APPLY, `t`<=step mask from current `q`, expected=`q ± 1` mod 2^WIDTH, remaining=N.
- **Step masks:**
  - UP: `t[0]`=1, `t[i]`=&`q[i-1:0]`.
  - DOWN: `t[0]`=1, `t[i]`=&(~`q[i-1:0]`).
  - Wrap-around is natural (UP from all-ones gives 0; DOWN from 0 gives all-ones).
- **CLR / APPLY:** last exactly one cycle. At the next posedge the bank resets or toggles; go to SETTLE with `t`<=0 and `tff_reset`<=0.
- **SETTLE:** `t`=0. At the posedge ending SETTLE, compare `q` to expected:
  - Mismatch: `err`<=1, abort, go to IDLE, pulse `done`.
  - Match and remaining>1 (UP/DOWN): remaining−1, expected±1, `t`<=new mask from `q`, go to APPLY.
  - Otherwise: go to IDLE, pulse `done`.
- `cmd_op`/`cmd_data` changes while busy are ignored. A source holding `cmd_valid` is accepted only once back in IDLE.
- An async reset asserted mid-command aborts immediately with reset values. The bank is re-reset via `tff_reset`, giving Q=0.

## Timing
- Accept edge E0. CLEAR/LOAD: CLR/APPLY in cycle 1, SETTLE in cycle 2, `done` and `cmd_ready` high in cycle 3.
- UP/DOWN with N steps: 2N cycles busy; `done` is high in cycle 2N+1 after E0. N=0 gives `done` in cycle 1.
- Back-to-back commands: the next command can be accepted at the edge ending the `done` cycle. `done` and `cmd_ready` are simultaneously high.
- `t` and `tff_reset` are never high together. `t` is high only in APPLY.
- Max command length: 2·(2^WIDTH−1) cycles.

## Test plan
Bench setup: WIDTH=4, four `T_FF` instances driven by `t`/`tff_reset`, checked against a reference model.

- Reset release: `reset` low for 3 cycles, then high → `tff_reset`=1 and `q`=0 during reset; `cmd_ready`=1 at the first edge after release; `t`=0 throughout.
- LOAD 4'b1011 from q=0 → `t`=1011 for exactly one cycle; `q`=1011 in cycle 2; `done` in cycle 3; `err`=0. Then LOAD 4'b0110 → `t`=1101, `q`=0110.
- UP N=5 from q=4'b1110 → sequence 1111, 0000, 0001, 0010, 0011 (wrap); busy 10 cycles; `done` in cycle 11. DOWN N=3 from 0001 → 0000, 1111, 1110.
- UP N=0 → `done` in cycle 1, no `t` activity; CLEAR from 1010 → `tff_reset` one cycle, `q`=0, `done` in cycle 3.
- Fault injection: force `q[2]` stuck at 0, then LOAD 4'b0100 → `err`=1 with `done` in cycle 3; `err` stays 1 until next accept, then clears.
- Async `reset` pulse mid-UP N=8 (during APPLY) → `t`=0 and `tff_reset`=1 immediately; after release `q`=0, IDLE, no `done` pulse; `cmd_valid` held while busy is accepted only once.
